soc_pio_in_debounced: RTL

//  Parametrised Avalon-MM input PIO for board switches and push-buttons.

---
 rtl/soc_pio_in_debounced.sv | 131 +++++++++++++
 1 files changed

// File: rtl/soc_pio_in_debounced.sv
// soc_pio_in_debounced
// Avalon-MM input PIO for switches and push-buttons. Every input bit is
// synchronised, debounced and edge-detected. Accepted edges latch into a
// write-1-to-clear capture register that drives a maskable level interrupt.
//
// Register map (word address):
//   0 data         RO  {0, stable}
//   1 reserved     RO  reads 0
//   2 irqmask      RW  bits [WIDTH-1:0]
//   3 edgecapture  W1C
module soc_pio_in_debounced #(
    parameter int WIDTH           = 8,      // 1..32
    parameter int DEBOUNCE_CYCLES = 50000,  // >= 1
    parameter int EDGE_TYPE       = 0       // 0 rising, 1 falling, 2 any
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0] DATA_MASK = 32'((64'd1 << WIDTH) - 64'd1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] stable;
    logic [CNT_W-1:0] cnt [WIDTH];
    logic [WIDTH-1:0] accept;
    logic [WIDTH-1:0] edge_set;
    logic [WIDTH-1:0] edge_clr;
    logic [WIDTH-1:0] edgecapture;
    logic [31:0]      irqmask;     // upper bits are forced to 0 on write
    logic [31:0]      rd_next;
    logic             wr_en;

    assign wr_en = chipselect && !write_n;

    // Two-flop synchroniser for the raw asynchronous inputs.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
        end
    end

    // A bit is accepted once it has differed from the stable level for
    // DEBOUNCE_CYCLES consecutive clocks; also picks which transitions capture.
    // NOTE: every always_comb output gets a default first, so no latch is inferred.
    always_comb begin
        accept   = '0;
        edge_set = '0;
        for (int i = 0; i < WIDTH; i++) begin
            accept[i] = (sync2[i] != stable[i]) && (cnt[i] == CNT_LAST);
        end
        case (EDGE_TYPE)
            0:       edge_set = accept & sync2;
            1:       edge_set = accept & ~sync2;
            default: edge_set = accept;
        endcase
    end

    // Per-bit debounce counters and the accepted (stable) level.
    // NOTE: the counter array is reset explicitly so a reset discards any partial count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync2[i] == stable[i] || cnt[i] == CNT_LAST) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
            stable <= stable ^ accept;
        end
    end

    assign edge_clr = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

    // Software registers: interrupt mask and edge capture (a new edge beats a clear).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask     <= '0;
            edgecapture <= '0;
        end else begin
            if (wr_en && address == 2'd2) begin
                irqmask <= writedata & DATA_MASK;
            end
            edgecapture <= (edgecapture & ~edge_clr) | edge_set;
        end
    end

    // Read mux for the currently addressed word.
    always_comb begin
        rd_next = '0;
        case (address)
            2'd0:    rd_next = 32'(stable);
            2'd2:    rd_next = irqmask;
            2'd3:    rd_next = 32'(edgecapture);
            default: rd_next = '0;
        endcase
    end

    // Registered read data: one-cycle latency regardless of chipselect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= rd_next;
        end
    end

    // Interrupt is a pure function of registers, never of in_port directly.
    assign irq = |(edgecapture & irqmask[WIDTH-1:0]);

endmodule
